vend_ctrl_n: RTL and testbench
==============================

// Module: vend_ctrl_n
// PURPOSE
//   N-product vending controller, successor to the 4-beverage dispenser.
//   - Accumulates coins into a credit register and checks selections against a parametrised price table.
//   - Holds the one-hot dispense output for a programmable time, then returns change.
//   - Sits between the coin acceptor / keypad front end and the dispense solenoid / change-hopper drivers.
// PARAMETERS
//   NUM_BEV     4                      number of products (2..16)
//   MONEY_W     10                     width of coin, credit and change values (cents)
//   PRICE_LIST  {10'd310,10'd175,10'd220,10'd125}  flattened NUM_BEV*MONEY_W prices; index 0 = LSBs
//   MAX_CREDIT  1000                   credit ceiling; must be < 2**MONEY_W
//   DISPENSE_CYC 4                     cycles dispense[] is held high (>=1)
//   STOCK_W     4                      stock counter width (VEND_STOCK_EN only)
//   STOCK_INIT  10                     per-product stock after reset (VEND_STOCK_EN only)
// PORTS
//   clk         in   1               clock
//   rst         in   1               synchronous, active-high reset
//   coin_valid  in   1               coin_val is valid this cycle
//   coin_val    in   MONEY_W         coin value
//   coin_rej    out  1               1-cycle pulse: coin refused, credit unchanged
//   sel_valid   in   1               selection strobe
//   sel_idx     in   $clog2(NUM_BEV) selected product
//   cancel      in   1               refund request
//   dispense    out  NUM_BEV         one-hot dispense drive
//   change_valid out 1               1-cycle pulse; change_amt valid
//   change_amt  out  MONEY_W         change / refund value
//   credit      out  MONEY_W         current credit
//   busy        out  1               high in DISPENSE and CHANGE
//   err_short   out  1               1-cycle pulse: credit < price
//   err_sel     out  1               1-cycle pulse: sel_idx >= NUM_BEV
//   sold_out    out  NUM_BEV         per-product empty flags (VEND_STOCK_EN only)
// BEHAVIOUR
//   Reset: state=IDLE; credit=0; dispense=0; change_amt=0. All pulses 0. Stock=STOCK_INIT under macro.
//   IDLE:
//     - coin_valid: if credit+coin_val <= MAX_CREDIT, credit += coin_val next cycle; else pulse coin_rej.
//       Sum is computed at MONEY_W+1 bits.
//     - sel_valid:
//       - sel_idx invalid -> err_sel pulse.
//       - price > credit -> err_short pulse, stay in IDLE.
//       - otherwise -> DISPENSE; dispense[sel_idx]=1 next cycle; change_amt = credit - price (registered).
//     - cancel: if credit>0 -> CHANGE with change_amt=credit; if credit==0, no action.
//   Simultaneous inputs, priority: cancel > sel_valid > coin.
//     - A coin arriving with cancel or an accepted selection gets coin_rej.
//     - A coin arriving with a rejected selection is processed normally.
//   Credit is evaluated on the registered value; a same-cycle coin does not count toward price.
//   DISPENSE: dispense held exactly DISPENSE_CYC cycles; then -> CHANGE. Coins -> coin_rej. sel/cancel ignored.
//   CHANGE: change_valid=1 for one cycle, including when change_amt==0. credit cleared the same cycle. -> IDLE.
//   Latency: sel_valid to dispense = 1 cycle; dispense fall to change_valid = 0 cycles (same edge).
//   rst mid-DISPENSE/CHANGE: aborts immediately, no change pulse, credit lost (by design).
// CONFIGURATION
//   VEND_STOCK_EN defined:
//     - Per-product STOCK_W counters, each decremented on entry to DISPENSE.
//     - sold_out[i] = (stock[i]==0).
//     - Selection of a sold-out product -> err_short pulse, credit retained.
//     - Counters never wrap below 0.
//   VEND_STOCK_EN undefined: unlimited stock; sold_out port and counters absent.
// STRUCTURE
//   vend_pkg: state enum {IDLE,DISPENSE,CHANGE}; price_at(idx) function; MONEY_W default.
//   Sub-module vend_credit_acc: credit register, saturation check, coin_rej generation.
//   FSM, dispense timer and stock live in vend_ctrl_n.
// TESTING
//   1. Coins 100,25 then sel 0 -> dispense=0001 for 4 cycles, change_valid with change_amt=0, credit=0.
//   2. Coins 100,100,100,25 then sel 3 -> dispense=1000; change_amt=15.
//   3. Credit 150, sel 1 (220) -> err_short pulse, credit stays 150. Then cancel -> change_amt=150.
//   4. Credit 990 + coin 25 -> coin_rej, credit 990. Coin during DISPENSE -> coin_rej.
//   5. cancel+sel+coin same cycle with credit 200 -> refund 200, coin_rej, no dispense.
//   6. VEND_STOCK_EN, STOCK_INIT=2: three buys of product 2 -> third gives err_short, sold_out[2]=1.

Source files
------------

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg : shared types and helpers for the N-product vending controller
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package vend_pkg;

    localparam int MONEY_W_DEF = 10;
    localparam int PRICE_VEC_W = 512;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_e;

    // Extract entry idx of width w from a zero-extended flattened price table
    function automatic logic [31:0] price_at(input logic [PRICE_VEC_W-1:0] list,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [PRICE_VEC_W-1:0] mask;
        logic [PRICE_VEC_W-1:0] sh;
        mask = (PRICE_VEC_W'(1) << w) - PRICE_VEC_W'(1);
        sh   = (list >> (idx * w)) & mask;
        return sh[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_credit_acc.sv
// ---------------------------------------------------------------------------
// vend_credit_acc : credit register with ceiling check and coin rejection
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vend_credit_acc #(
    parameter int MONEY_W    = 10,
    parameter int MAX_CREDIT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid_i,
    input  logic [MONEY_W-1:0] coin_val_i,
    input  logic               accept_en_i,
    input  logic               clear_i,
    output logic [MONEY_W-1:0] credit_o,
    output logic               coin_rej_o
);

    logic [MONEY_W-1:0] credit_q;
    logic               coin_rej_q;
    logic [MONEY_W:0]   w_sum;
    logic               w_fits;
    logic               w_take;

    // One extra bit so an overflowing sum still compares correctly
    assign w_sum  = {1'b0, credit_q} + {1'b0, coin_val_i};
    assign w_fits = (w_sum <= (MONEY_W+1)'(MAX_CREDIT));
    assign w_take = coin_valid_i && accept_en_i && w_fits;

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            coin_rej_q <= coin_valid_i && !w_take;
            if (clear_i) begin
                credit_q <= '0;
            end else if (w_take) begin
                credit_q <= w_sum[MONEY_W-1:0];
            end
        end
    end

    assign credit_o   = credit_q;
    assign coin_rej_o = coin_rej_q;

endmodule

`default_nettype wire

// File: rtl/vend_ctrl_n.sv
// ---------------------------------------------------------------------------
// vend_ctrl_n : N-product vending controller (FSM, dispense timer, stock)
// Optional feature: VEND_STOCK_EN adds per-product stock counters and sold_out
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vend_ctrl_n
    import vend_pkg::*;
#(
    parameter int                          NUM_BEV      = 4,
    parameter int                          MONEY_W      = MONEY_W_DEF,
    parameter logic [NUM_BEV*MONEY_W-1:0]  PRICE_LIST   = {10'd310, 10'd175, 10'd220, 10'd125},
    parameter int                          MAX_CREDIT   = 1000,
    parameter int                          DISPENSE_CYC = 4,
    parameter int                          STOCK_W      = 4,
    parameter int                          STOCK_INIT   = 10,
    localparam int                         IDX_W        = (NUM_BEV > 1) ? $clog2(NUM_BEV) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_val,
    output logic               coin_rej,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    input  logic               cancel,
    output logic [NUM_BEV-1:0] dispense,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amt,
    output logic [MONEY_W-1:0] credit,
    output logic               busy,
    output logic               err_short,
`ifdef VEND_STOCK_EN
    output logic [NUM_BEV-1:0] sold_out,
`endif
    output logic               err_sel
);

    localparam int TMR_W = $clog2(DISPENSE_CYC) + 1;
    localparam logic [PRICE_VEC_W-1:0] PRICE_EXT = PRICE_VEC_W'(PRICE_LIST);

    state_e             state_q;
    logic [NUM_BEV-1:0] dispense_q;
    logic [MONEY_W-1:0] change_amt_q;
    logic               change_valid_q;
    logic               busy_q;
    logic               err_short_q;
    logic               err_sel_q;
    logic [TMR_W-1:0]   timer_q;

    logic [MONEY_W-1:0] w_credit;
    logic [MONEY_W-1:0] w_price;
    logic               w_idle;
    logic               w_idx_ok;
    logic               w_sel_soldout;
    logic               w_sel_req;
    logic               w_sel_accept;
    logic               w_refund;
    logic               w_disp_end;
    logic               w_credit_clr;
    logic               w_coin_en;

    assign w_idle     = (state_q == IDLE);
    assign w_idx_ok   = (32'(sel_idx) < NUM_BEV);
    assign w_price    = MONEY_W'(price_at(PRICE_EXT, 32'(sel_idx), MONEY_W));

    // cancel outranks a selection, which outranks a coin
    assign w_sel_req    = w_idle && !cancel && sel_valid;
    assign w_sel_accept = w_sel_req && w_idx_ok && !w_sel_soldout && (w_price <= w_credit);
    assign w_refund     = w_idle && cancel && (w_credit != '0);
    assign w_disp_end   = (state_q == DISPENSE) && (timer_q == '0);
    assign w_credit_clr = w_refund || w_disp_end;
    assign w_coin_en    = w_idle && !cancel && !w_sel_accept;

    vend_credit_acc #(
        .MONEY_W    (MONEY_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .coin_valid_i (coin_valid),
        .coin_val_i   (coin_val),
        .accept_en_i  (w_coin_en),
        .clear_i      (w_credit_clr),
        .credit_o     (w_credit),
        .coin_rej_o   (coin_rej)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dispense_q     <= '0;
            change_amt_q   <= '0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_short_q    <= 1'b0;
            err_sel_q      <= 1'b0;
            timer_q        <= '0;
        end else begin
            change_valid_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_sel_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_refund) begin
                        state_q        <= CHANGE;
                        change_amt_q   <= w_credit;
                        change_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (w_sel_req) begin
                        if (!w_idx_ok) begin
                            err_sel_q <= 1'b1;
                        end else if (!w_sel_accept) begin
                            err_short_q <= 1'b1;
                        end else begin
                            state_q      <= DISPENSE;
                            dispense_q   <= NUM_BEV'(1) << sel_idx;
                            change_amt_q <= w_credit - w_price;
                            timer_q      <= TMR_W'(DISPENSE_CYC - 1);
                            busy_q       <= 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    if (w_disp_end) begin
                        state_q        <= CHANGE;
                        dispense_q     <= '0;
                        change_valid_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                CHANGE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    dispense_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_BEV];

    // A product can only be accepted while its counter is non-zero, so no wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BEV; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else if (w_sel_accept) begin
            stock_q[sel_idx] <= stock_q[sel_idx] - STOCK_W'(1);
        end
    end

    assign w_sel_soldout = w_idx_ok && (stock_q[sel_idx] == '0);

    for (genvar g = 0; g < NUM_BEV; g++) begin : g_sold_out
        assign sold_out[g] = (stock_q[g] == '0);
    end
`else
    assign w_sel_soldout = 1'b0;
`endif

    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = w_credit;
    assign busy         = busy_q;
    assign err_short    = err_short_q;
    assign err_sel      = err_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_n : directed self-checking bench for vend_ctrl_n
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vend_ctrl_n;

    localparam int NUM_BEV = 4;
    localparam int MONEY_W = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               coin_valid;
    logic [MONEY_W-1:0] coin_val;
    logic               coin_rej;
    logic               sel_valid;
    logic [1:0]         sel_idx;
    logic               cancel;
    logic [NUM_BEV-1:0] dispense;
    logic               change_valid;
    logic [MONEY_W-1:0] change_amt;
    logic [MONEY_W-1:0] credit;
    logic               busy;
    logic               err_short;
    logic               err_sel;
`ifdef VEND_STOCK_EN
    logic [NUM_BEV-1:0] sold_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_ctrl_n #(
`ifdef VEND_STOCK_EN
        .STOCK_INIT   (2),
`endif
        .NUM_BEV      (NUM_BEV),
        .MONEY_W      (MONEY_W),
        .PRICE_LIST   ({10'd310, 10'd175, 10'd220, 10'd125}),
        .MAX_CREDIT   (1000),
        .DISPENSE_CYC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .coin_rej     (coin_rej),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .busy         (busy),
        .err_short    (err_short),
`ifdef VEND_STOCK_EN
        .sold_out     (sold_out),
`endif
        .err_sel      (err_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_val   = MONEY_W'(v);
        tick();
        coin_valid = 1'b0;
        chk("coin_accept_rej", 32'(coin_rej), 0);
    endtask

    // Selection expected to be accepted: full dispense window then change pulse
    task automatic buy(input int idx, input int exp_change);
        sel_valid = 1'b1;
        sel_idx   = 2'(idx);
        tick();
        sel_valid = 1'b0;
        chk("buy_disp_c1", 32'(dispense), 32'(1) << idx);
        chk("buy_busy", 32'(busy), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("buy_disp_hold", 32'(dispense), 32'(1) << idx);
            chk("buy_no_chg", 32'(change_valid), 0);
        end
        tick();
        chk("buy_disp_fall", 32'(dispense), 0);
        chk("buy_chg_valid", 32'(change_valid), 1);
        chk("buy_chg_amt", 32'(change_amt), 32'(exp_change));
        chk("buy_credit_clr", 32'(credit), 0);
        tick();
        chk("buy_chg_pulse_end", 32'(change_valid), 0);
        chk("buy_idle", 32'(busy), 0);
    endtask

    task automatic refund(input int exp_amt);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("refund_valid", 32'(change_valid), 1);
        chk("refund_amt", 32'(change_amt), 32'(exp_amt));
        chk("refund_credit", 32'(credit), 0);
        tick();
        chk("refund_end", 32'(change_valid), 0);
    endtask

    initial begin
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_val   = '0;
        sel_valid  = 1'b0;
        sel_idx    = '0;
        cancel     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_change_amt", 32'(change_amt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", {29'd0, change_valid, err_short, err_sel}, 0);

        // 1: exact price on product 0 (125)
        coin(100);
        coin(25);
        chk("t1_credit", 32'(credit), 125);
        buy(0, 0);

        // 2: 325 credit on product 3 (310) -> 15 change; coin during dispense refused
        coin(100);
        coin(100);
        coin(100);
        coin(25);
        chk("t2_credit", 32'(credit), 325);
        sel_valid = 1'b1;
        sel_idx   = 2'd3;
        tick();
        sel_valid = 1'b0;
        chk("t2_disp", 32'(dispense), 8);
        chk("t2_chg_amt", 32'(change_amt), 15);
        coin_valid = 1'b1;
        coin_val   = 10'd25;
        tick();
        coin_valid = 1'b0;
        chk("t2_disp_coin_rej", 32'(coin_rej), 1);
        chk("t2_disp_credit", 32'(credit), 325);
        tick();
        tick();
        chk("t2_disp_c4", 32'(dispense), 8);
        tick();
        chk("t2_chg_valid", 32'(change_valid), 1);
        chk("t2_chg_amt_out", 32'(change_amt), 15);
        chk("t2_credit_clr", 32'(credit), 0);
        tick();

        // 3: short credit on product 1 (220), then refund
        coin(100);
        coin(50);
        sel_valid = 1'b1;
        sel_idx   = 2'd1;
        tick();
        sel_valid = 1'b0;
        chk("t3_err_short", 32'(err_short), 1);
        chk("t3_credit", 32'(credit), 150);
        chk("t3_no_disp", 32'(dispense), 0);
        tick();
        chk("t3_err_pulse_end", 32'(err_short), 0);
        refund(150);

        // 4: ceiling - 990 + 25 refused, 990 + 10 lands exactly on 1000
        coin(990);
        coin_valid = 1'b1;
        coin_val   = 10'd25;
        tick();
        coin_valid = 1'b0;
        chk("t4_coin_rej", 32'(coin_rej), 1);
        chk("t4_credit_hold", 32'(credit), 990);
        tick();
        chk("t4_rej_pulse_end", 32'(coin_rej), 0);
        coin(10);
        chk("t4_credit_max", 32'(credit), 1000);
        refund(1000);

        // 5: cancel + sel + coin together with 200 credit
        coin(200);
        cancel     = 1'b1;
        sel_valid  = 1'b1;
        sel_idx    = 2'd0;
        coin_valid = 1'b1;
        coin_val   = 10'd25;
        tick();
        cancel     = 1'b0;
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        chk("t5_chg_valid", 32'(change_valid), 1);
        chk("t5_chg_amt", 32'(change_amt), 200);
        chk("t5_coin_rej", 32'(coin_rej), 1);
        chk("t5_no_disp", 32'(dispense), 0);
        chk("t5_credit", 32'(credit), 0);
        tick();

        // Rejected selection with a same-cycle coin: coin counts, but not toward price
        coin(100);
        sel_valid  = 1'b1;
        sel_idx    = 2'd0;
        coin_valid = 1'b1;
        coin_val   = 10'd25;
        tick();
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        chk("t7_err_short", 32'(err_short), 1);
        chk("t7_coin_ok", 32'(coin_rej), 0);
        chk("t7_credit", 32'(credit), 125);
        buy(0, 0);

`ifdef VEND_STOCK_EN
        // 6: product 2 stock of 2; product 0 already bought twice
        coin(175);
        buy(2, 0);
        coin(200);
        buy(2, 25);
        coin(175);
        sel_valid = 1'b1;
        sel_idx   = 2'd2;
        tick();
        sel_valid = 1'b0;
        chk("t6_err_short", 32'(err_short), 1);
        chk("t6_credit", 32'(credit), 175);
        chk("t6_no_disp", 32'(dispense), 0);
        chk("t6_sold_out", 32'(sold_out), 5);
        refund(175);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
